// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter
// Description : Round-robin arbiter sharing the register-file write port
//               between N_REQ requesters over a valid/ready handshake. The
//               winning index/data/enable are registered one cycle after the
//               handshake and drive the write-select decoder and bank enables.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               stall_i         - datapath hold, blocks all grants
//               req_valid_i     - per-requester write request
//               req_addr_i      - packed destination indices
//               req_data_i      - packed write data
//               req_ready_o     - one-hot-or-zero combinational grant
//               wr_en_o         - registered write enable
//               wr_addr_o       - registered write index
//               wr_data_o       - registered write data
//               grant_id_o      - registered index of last accepted requester
//               busy_cnt_o      - saturating count of stalled request cycles
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
  parameter int N_REQ             = 4,
  parameter int DATA_WIDTH        = 32,
  parameter int ADDR_WIDTH        = 5,
  parameter bit ZERO_REG_WRITABLE = 1'b0,
  localparam int ID_W             = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall_i,
  input  logic [N_REQ-1:0]            req_valid_i,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [N_REQ-1:0]            req_ready_o,
  output logic                        wr_en_o,
  output logic [ADDR_WIDTH-1:0]       wr_addr_o,
  output logic [DATA_WIDTH-1:0]       wr_data_o,
  output logic [ID_W-1:0]             grant_id_o,
  output logic [15:0]                 busy_cnt_o
);

  localparam logic [ID_W:0]   N_REQ_EXT = (ID_W+1)'(N_REQ);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(N_REQ - 1);

  logic [ID_W-1:0]       ptr;
  logic [ID_W-1:0]       grant_idx;
  logic                  found;
  logic                  transfer;
  logic [ID_W:0]         scan_idx;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_write_ok;

  // Scan ptr, ptr+1, ... wrapping modulo N_REQ; first valid requester wins.
  // The extra index bit lets the sum exceed N_REQ-1 before wrapping, which
  // keeps the scan correct for non-power-of-two requester counts.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      scan_idx = {1'b0, ptr} + (ID_W+1)'(i);
      if (scan_idx >= N_REQ_EXT) begin
        scan_idx = scan_idx - N_REQ_EXT;
      end
      if (!found && req_valid_i[scan_idx[ID_W-1:0]]) begin
        found     = 1'b1;
        grant_idx = scan_idx[ID_W-1:0];
      end
    end
  end

  // Reset and stall both suppress the grant so nothing is accepted.
  assign transfer    = found && !stall_i && !reset;
  assign req_ready_o = transfer ? (N_REQ'(1) << grant_idx) : '0;

  // Constant-index mux avoids a variable part-select on the packed buses.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (ID_W'(k) == grant_idx) begin
        sel_addr = req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Register 0 writes still complete the handshake but do not reach the bank.
  assign sel_write_ok = ZERO_REG_WRITABLE || (sel_addr != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr        <= '0;
      wr_en_o    <= 1'b0;
      wr_addr_o  <= '0;
      wr_data_o  <= '0;
      grant_id_o <= '0;
      busy_cnt_o <= '0;
    end else begin
      wr_en_o <= transfer && sel_write_ok;
      if (transfer) begin
        wr_addr_o  <= sel_addr;
        wr_data_o  <= sel_data;
        grant_id_o <= grant_idx;
        ptr        <= (grant_idx == LAST_ID) ? '0 : grant_idx + ID_W'(1);
      end
      if ((|req_valid_i) && stall_i && (busy_cnt_o != 16'hFFFF)) begin
        busy_cnt_o <= busy_cnt_o + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Round-robin arbiter that shares the register file's single write port between N_REQ requesters (e.g. ALU writeback, load unit, link-register write).
- Accepts one write per cycle via a valid/ready handshake.
- Registers the winning address/data/enable one cycle later.
- Its wr_addr_o/wr_en_o drive the 5-to-32 write-select decoder and the register bank enables.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 32, register data width
ADDR_WIDTH, 5, register index width (32 registers)
ZERO_REG_WRITABLE, 0, 0: writes to register 0 are accepted but suppressed (wr_en_o stays 0); 1: passed through

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall_i  input  1  datapath hold; when 1 no request is granted
req_valid_i  input  N_REQ  per-requester write request
req_addr_i  input  N_REQ*ADDR_WIDTH  packed destination indices, requester k at [k*ADDR_WIDTH +: ADDR_WIDTH]
req_data_i  input  N_REQ*DATA_WIDTH  packed write data, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
req_ready_o  output  N_REQ  one-hot-or-zero grant (combinational)
wr_en_o  output  1  registered write enable to register bank
wr_addr_o  output  ADDR_WIDTH  registered write index (feeds decoder)
wr_data_o  output  DATA_WIDTH  registered write data
grant_id_o  output  log2(N_REQ) (min 1)  registered index of last accepted requester
busy_cnt_o  output  16  saturating count of cycles with >=1 valid request but no grant

Behaviour:
- Reset (reset=1 at clk edge):
  - Outputs: wr_en_o=0, wr_addr_o=0, wr_data_o=0, grant_id_o=0, busy_cnt_o=0.
  - Priority pointer ptr=0.
  - Takes effect regardless of stall_i or requests.
  - A request presented in the reset cycle is not accepted.
  - req_ready_o is forced to 0 while reset=1.
- Grant, combinational:
  - If stall_i=0 and any req_valid_i set, exactly one req_ready_o bit is set: the first valid index found scanning ptr, ptr+1, ... wrapping mod N_REQ.
  - Otherwise req_ready_o=0.
  - req_ready_o never asserts for a requester whose valid is 0.
- Transfer: occurs for requester k when req_valid_i[k] & req_ready_o[k] at a rising edge.
- On transfer to k, next cycle:
  - wr_addr_o=addr_k, wr_data_o=data_k, grant_id_o=k.
  - wr_en_o=1, except wr_en_o=0 if addr_k==0 and ZERO_REG_WRITABLE==0.
  - ptr <= (k+1) mod N_REQ.
- Latency: exactly 1 cycle from handshake to wr_en_o. The port sustains one write per cycle.
- No transfer in a cycle (stall_i=1 or no valid):
  - wr_en_o <= 0.
  - wr_addr_o, wr_data_o, grant_id_o hold their values.
  - ptr holds.
- stall_i=1:
  - No grant, ptr frozen.
  - Requests pending during stall keep their relative priority when stall drops.
- busy_cnt_o: increments when (|req_valid_i) & stall_i and not in reset. Saturates at 16'hFFFF (no wrap).
- Requesters must hold valid/addr/data stable until ready; the arbiter does not buffer unaccepted requests.
- Fairness: with all N_REQ requesters continuously valid, grants rotate 0,1,...,N_REQ-1,0,...; each requester waits at most N_REQ-1 cycles.
- Same-address back-to-back writes from different requesters are both issued in grant order; the later one wins in the register bank.
- Pointer wrap: grant to N_REQ-1 sets ptr=0.
- No internal state other than ptr, output registers and busy_cnt_o.

Test Plan:
- Reset release, no requests -> wr_en_o=0, req_ready_o=0000, busy_cnt_o=0 for 10 cycles.
- Req 2 valid, addr=5'd7, data=32'hDEADBEEF -> req_ready_o=0100 same cycle; next cycle wr_en_o=1, wr_addr_o=7, wr_data_o=DEADBEEF, grant_id_o=2; ptr then 3.
- All four valid continuously for 8 cycles from ptr=0 -> grant order 0,1,2,3,0,1,2,3; wr_en_o=1 on every cycle after the first.
- Req 1 writes addr=0, data=32'h12345678 (ZERO_REG_WRITABLE=0) -> handshake completes, grant_id_o=1, wr_en_o=0.
- Req 0 and 3 valid with stall_i=1 for 5 cycles -> req_ready_o=0000, busy_cnt_o=5, wr_en_o=0. Stall drops with ptr=2 -> req 3 granted first, then req 0.
- Reset asserted mid-stream with all four valid -> next cycle all outputs zero and ptr=0. After release, requester 0 is granted first.
